// File: rtl/cart_pkg.sv
// Shared constants for the cartridge image loader: FSM encoding, config
// layout and default memory geometry.
package cart_pkg;

  localparam int CFG_BYTE_COUNT     = 5;
  localparam int DEF_PRG_BANK_BYTES = 16384;
  localparam int DEF_CHR_BYTES      = 8192;

  // Config bit selecting two PRG banks instead of one.
  localparam int CFG_PRG_DOUBLE_BIT = 33;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CFG    = 3'd1;
  localparam logic [2:0] ST_PRG    = 3'd2;
  localparam logic [2:0] ST_PRG_WR = 3'd3;
  localparam logic [2:0] ST_CHR    = 3'd4;
  localparam logic [2:0] ST_CHR_WR = 3'd5;

  // Index of the final PRG byte for the selected bank count.
  function automatic logic [15:0] prg_last_index(input logic double_bank,
                                                 input int   bank_bytes);
    int total;
    total = double_bank ? (2 * bank_bytes) : bank_bytes;
    return 16'(total - 1);
  endfunction

endpackage

// File: rtl/cart_loader.sv
// Streams a cartridge image (5 config bytes, PRG, CHR) from a valid/ready
// byte interface into the PRG and CHR memories, one write strobe per byte.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start_in
// CFG       | collecting the 5 config bytes, LSB first
// PRG       | waiting for the next PRG byte
// PRG_WR    | single-cycle PRG write strobe
// CHR       | waiting for the next CHR byte
// CHR_WR    | single-cycle CHR write strobe
module cart_loader
  import cart_pkg::*;
#(
  parameter int PRG_BANK_BYTES = DEF_PRG_BANK_BYTES,
  parameter int CHR_BYTES      = DEF_CHR_BYTES
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic [7:0]  din_in,
  input  logic        din_valid_in,
  output logic        din_ready_out,
  output logic [39:0] cfg_out,
  output logic        cfg_upd_out,
  output logic        prg_nce_out,
  output logic        prg_r_nw_out,
  output logic [14:0] prg_a_out,
  output logic [7:0]  prg_d_out,
  output logic [13:0] chr_a_out,
  output logic        chr_r_nw_out,
  output logic [7:0]  chr_d_out,
  output logic        busy_out,
  output logic        done_out
);

  localparam logic [15:0] CFG_LAST = 16'(CFG_BYTE_COUNT - 1);
  localparam logic [15:0] CHR_LAST = 16'(CHR_BYTES - 1);

  logic [2:0]  state_q;
  logic [15:0] cnt_q;
  logic [39:0] cfg_q;
  logic [14:0] prg_a_q;
  logic [7:0]  prg_d_q;
  logic [12:0] chr_a_q;
  logic [7:0]  chr_d_q;
  logic        cfg_upd_q;
  logic        done_q;
  logic        accept;
  logic [15:0] prg_last;

  assign din_ready_out = (state_q == ST_CFG) || (state_q == ST_PRG) ||
                         (state_q == ST_CHR);
  assign accept        = din_valid_in & din_ready_out;
  assign prg_last      = prg_last_index(cfg_q[CFG_PRG_DOUBLE_BIT], PRG_BANK_BYTES);

  // Strobes decode straight from state so a reset drops them immediately.
  assign prg_nce_out   = (state_q != ST_PRG_WR);
  assign prg_r_nw_out  = (state_q != ST_PRG_WR);
  assign chr_r_nw_out  = (state_q != ST_CHR_WR);
  assign busy_out      = (state_q != ST_IDLE);

  assign cfg_out       = cfg_q;
  assign cfg_upd_out   = cfg_upd_q;
  assign done_out      = done_q;
  assign prg_a_out     = prg_a_q;
  assign prg_d_out     = prg_d_q;
  assign chr_a_out     = {1'b0, chr_a_q};
  assign chr_d_out     = chr_d_q;

  // Load sequencer: byte counter, config assembly and address/data latches.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cfg_q     <= '0;
      prg_a_q   <= '0;
      prg_d_q   <= '0;
      chr_a_q   <= '0;
      chr_d_q   <= '0;
      cfg_upd_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cfg_upd_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            state_q <= ST_CFG;
            cnt_q   <= '0;
          end
        end
        ST_CFG: begin
          if (accept) begin
            case (cnt_q[2:0])
              3'd0:    cfg_q[7:0]   <= din_in;
              3'd1:    cfg_q[15:8]  <= din_in;
              3'd2:    cfg_q[23:16] <= din_in;
              3'd3:    cfg_q[31:24] <= din_in;
              3'd4:    cfg_q[39:32] <= din_in;
              default: ;
            endcase
            if (cnt_q == CFG_LAST) begin
              state_q   <= ST_PRG;
              cnt_q     <= '0;
              cfg_upd_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        ST_PRG: begin
          if (accept) begin
            prg_d_q <= din_in;
            prg_a_q <= cnt_q[14:0];
            state_q <= ST_PRG_WR;
          end
        end
        ST_PRG_WR: begin
          if (cnt_q == prg_last) begin
            state_q <= ST_CHR;
            cnt_q   <= '0;
          end else begin
            state_q <= ST_PRG;
            cnt_q   <= cnt_q + 16'd1;
          end
        end
        ST_CHR: begin
          if (accept) begin
            chr_d_q <= din_in;
            chr_a_q <= cnt_q[12:0];
            state_q <= ST_CHR_WR;
          end
        end
        ST_CHR_WR: begin
          cnt_q <= cnt_q + 16'd1;
          if (cnt_q == CHR_LAST) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_CHR;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_loader.sv
// Randomised bench for cart_loader: an image is generated per load, the
// expected PRG/CHR writes are derived from byte position in the image, and
// every observed write strobe is matched against them in order.
module tb_cart_loader;

  localparam int PB = 512;
  localparam int CB = 256;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        start_in = 1'b0;
  logic [7:0]  din_in = '0;
  logic        din_valid_in = 1'b0;
  logic        din_ready_out;
  logic [39:0] cfg_out;
  logic        cfg_upd_out;
  logic        prg_nce_out, prg_r_nw_out;
  logic [14:0] prg_a_out;
  logic [7:0]  prg_d_out;
  logic [13:0] chr_a_out;
  logic        chr_r_nw_out;
  logic [7:0]  chr_d_out;
  logic        busy_out, done_out;

  cart_loader #(.PRG_BANK_BYTES(PB), .CHR_BYTES(CB)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .din_in(din_in), .din_valid_in(din_valid_in), .din_ready_out(din_ready_out),
    .cfg_out(cfg_out), .cfg_upd_out(cfg_upd_out),
    .prg_nce_out(prg_nce_out), .prg_r_nw_out(prg_r_nw_out),
    .prg_a_out(prg_a_out), .prg_d_out(prg_d_out),
    .chr_a_out(chr_a_out), .chr_r_nw_out(chr_r_nw_out), .chr_d_out(chr_d_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int a;
    int d;
  } wr_t;

  wr_t prg_q[$];
  wr_t chr_q[$];
  int  n_tests = 0;
  int  n_fail = 0;
  int  prg_strobes = 0, chr_strobes = 0, done_cnt = 0, upd_cnt = 0, viol = 0;
  logic [39:0] rand_cfg;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: match write strobes in order, count pulses and rule breaks.
  always @(negedge clk_in) begin : mon
    wr_t e;
    if (rst_n_in) begin
      if (!prg_nce_out || !prg_r_nw_out) begin
        prg_strobes++;
        if (prg_nce_out !== prg_r_nw_out || din_ready_out) viol++;
        chk("prg_pending", 64'(prg_q.size() > 0), 64'(1));
        if (prg_q.size() > 0) begin
          e = prg_q.pop_front();
          chk("prg_a", 64'(prg_a_out), 64'(e.a));
          chk("prg_d", 64'(prg_d_out), 64'(e.d));
        end
      end
      if (!chr_r_nw_out) begin
        chr_strobes++;
        if (din_ready_out) viol++;
        chk("chr_pending", 64'(chr_q.size() > 0), 64'(1));
        if (chr_q.size() > 0) begin
          e = chr_q.pop_front();
          chk("chr_a", 64'(chr_a_out), 64'(e.a));
          chk("chr_d", 64'(chr_d_out), 64'(e.d));
        end
      end
      if (chr_a_out[13]) viol++;
      if (done_out && cfg_upd_out) viol++;
      if (din_ready_out && !busy_out) viol++;
      if (done_out) done_cnt++;
      if (cfg_upd_out) upd_cnt++;
    end
  end

  task automatic run_load(input logic [39:0] cfg, input int pvalid,
                          input int abort_a, input int start_a);
    logic [7:0] img[$];
    logic [7:0] b;
    int nprg, idx, iters, d0, u0, v0, ps0, cs0;
    logic acc;
    bit aborted;
    nprg = cfg[33] ? 2 * PB : PB;
    for (int k = 0; k < 5; k++) img.push_back(cfg[8*k +: 8]);
    for (int k = 0; k < nprg; k++) begin
      b = 8'($urandom_range(0, 255));
      img.push_back(b);
      prg_q.push_back('{k, int'(b)});
    end
    for (int k = 0; k < CB; k++) begin
      b = 8'($urandom_range(0, 255));
      img.push_back(b);
      chr_q.push_back('{k, int'(b)});
    end
    d0 = done_cnt; u0 = upd_cnt; v0 = viol;
    @(negedge clk_in); #1;
    start_in = 1'b1;
    @(negedge clk_in); #1;
    start_in = 1'b0;
    chk("busy_after_start", 64'(busy_out), 64'(1));
    idx = 0; iters = 0; aborted = 0;
    while (idx < img.size()) begin
      if (abort_a >= 0 && !prg_nce_out && prg_a_out == 15'(abort_a)) begin
        rst_n_in = 1'b0;
        #1;
        chk("abort_prg_nce", 64'(prg_nce_out), 64'(1));
        chk("abort_prg_r_nw", 64'(prg_r_nw_out), 64'(1));
        chk("abort_busy", 64'(busy_out), 64'(0));
        chk("abort_ready", 64'(din_ready_out), 64'(0));
        chk("abort_cfg", 64'(cfg_out), 64'(0));
        chk("abort_prg_a", 64'(prg_a_out), 64'(0));
        prg_q.delete();
        chr_q.delete();
        aborted = 1;
        break;
      end
      din_in       = img[idx];
      din_valid_in = (int'($urandom_range(0, 99)) < pvalid);
      start_in     = (start_a >= 0 && !prg_nce_out && prg_a_out == 15'(start_a));
      acc          = din_valid_in && din_ready_out;
      @(negedge clk_in); #1;
      iters++;
      if (acc) begin
        idx++;
        if (idx == 5) begin
          chk("cfg_upd_pulse", 64'(cfg_upd_out), 64'(1));
          chk("cfg_value", 64'(cfg_out), 64'(cfg));
        end
      end
      if (iters > 40000) begin
        chk("load_timeout", 64'(idx), 64'(img.size()));
        break;
      end
    end
    din_valid_in = 1'b0;
    start_in = 1'b0;
    if (aborted) begin
      repeat (2) @(negedge clk_in);
      #1;
      rst_n_in = 1'b1;
      ps0 = prg_strobes; cs0 = chr_strobes;
      repeat (30) begin
        din_in = 8'($urandom_range(0, 255));
        din_valid_in = 1'b1;
        @(negedge clk_in); #1;
      end
      din_valid_in = 1'b0;
      chk("post_abort_prg_strobes", 64'(prg_strobes), 64'(ps0));
      chk("post_abort_chr_strobes", 64'(chr_strobes), 64'(cs0));
      chk("post_abort_busy", 64'(busy_out), 64'(0));
      chk("post_abort_ready", 64'(din_ready_out), 64'(0));
      return;
    end
    @(negedge clk_in); #1;
    chk("done_pulse", 64'(done_out), 64'(1));
    chk("busy_at_done", 64'(busy_out), 64'(0));
    repeat (3) @(negedge clk_in);
    #1;
    chk("done_count", 64'(done_cnt - d0), 64'(1));
    chk("upd_count", 64'(upd_cnt - u0), 64'(1));
    chk("prg_left", 64'(prg_q.size()), 64'(0));
    chk("chr_left", 64'(chr_q.size()), 64'(0));
    chk("violations", 64'(viol - v0), 64'(0));
    chk("cfg_retained", 64'(cfg_out), 64'(cfg));
    if (pvalid == 100)
      chk("throughput_cycles", 64'(iters), 64'(5 + 2 * (nprg + CB) - 1));
  endtask

  initial begin
    #1;
    chk("rst_busy", 64'(busy_out), 64'(0));
    chk("rst_done", 64'(done_out), 64'(0));
    chk("rst_upd", 64'(cfg_upd_out), 64'(0));
    chk("rst_ready", 64'(din_ready_out), 64'(0));
    chk("rst_cfg", 64'(cfg_out), 64'(0));
    chk("rst_prg_nce", 64'(prg_nce_out), 64'(1));
    chk("rst_prg_r_nw", 64'(prg_r_nw_out), 64'(1));
    chk("rst_chr_r_nw", 64'(chr_r_nw_out), 64'(1));
    chk("rst_prg_a", 64'(prg_a_out), 64'(0));
    chk("rst_chr_a", 64'(chr_a_out), 64'(0));
    chk("rst_prg_d", 64'(prg_d_out), 64'(0));
    chk("rst_chr_d", 64'(chr_d_out), 64'(0));
    repeat (3) @(negedge clk_in);
    #1;
    rst_n_in = 1'b1;

    run_load(40'h02_00_00_00_00, 100, -1, -1);
    run_load(40'h00_02_00_00_00, 40, -1, -1);
    rand_cfg = {8'($urandom_range(0, 255)), 32'($urandom)};
    run_load(rand_cfg, 60, -1, 16);
    run_load(40'h02_00_00_00_A5, 70, 'h123, -1);
    run_load(40'h00_00_00_01_00, 50, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
